game_session_ctrl: RTL and testbench

Game-session sequencer for the whack-a-mole datapath. It produces the 2-bit game-phase code `select` (00 idle, 01 playing, 10 over) and the 32-bit running `score` that the score-latch stage consumes. It runs the fixed-length play countdown, 35 s by default, and counts hits only while play is active. It sits between the debounced button / mole-hit logic and the score-hold and display stages.

---
 rtl/game_session_ctrl.sv | 94 +++++++++
 tb/tb_game_session_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - whack-a-mole session sequencer: phase, countdown and score
module game_session_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int GAME_SECONDS = 35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  output logic [1:0]  select,
  output logic [31:0] score,
  output logic [5:0]  seconds_left,
  output logic        tick_1hz
);

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0]    SECS_INIT  = 6'(GAME_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic [PW-1:0] presc_q;
  logic [31:0]   score_q;
  logic [5:0]    secs_q;
  logic          tick_q;
  logic          start_edge;
  logic          presc_last;

  assign start_edge = start & ~start_q;
  assign presc_last = (presc_q == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_PLAY;
      S_PLAY:  if (presc_last && (secs_q == 6'd1)) state_d = S_OVER;
      S_OVER:  if (start_edge) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // start_q resets high so a start button held through reset cannot launch a game
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b1;
      presc_q <= '0;
      score_q <= '0;
      secs_q  <= SECS_INIT;
      tick_q  <= 1'b0;
    end else begin
      start_q <= start;
      tick_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          secs_q  <= SECS_INIT;
          if (start_edge) score_q <= '0;
        end
        S_PLAY: begin
          presc_q <= presc_last ? '0 : presc_q + PW'(1);
          if (presc_last) begin
            secs_q <= secs_q - 6'd1;
            tick_q <= 1'b1;
          end
          // a hit on the cycle that times out still counts
          if (hit && (score_q != 32'hFFFF_FFFF)) score_q <= score_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    select       = state_q;
    score        = score_q;
    seconds_left = secs_q;
    tick_1hz     = tick_q;
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb/tb_game_session_ctrl.sv - directed bench for game_session_ctrl (CLK_HZ=4, GAME_SECONDS=3)
module tb_game_session_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        hit;
  logic [1:0]  select;
  logic [31:0] score;
  logic [5:0]  seconds_left;
  logic        tick_1hz;

  int n_checks = 0;
  int n_fail   = 0;

  game_session_ctrl #(.CLK_HZ(4), .GAME_SECONDS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hit          (hit),
    .select       (select),
    .score        (score),
    .seconds_left (seconds_left),
    .tick_1hz     (tick_1hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hits_seen;
    reset = 1'b1;
    start = 1'b1;
    hit   = 1'b0;
    cyc(2);
    chk("reset_select", 32'(select), 32'd0);
    chk("reset_score", score, 32'd0);
    chk("reset_secs", 32'(seconds_left), 32'd3);
    chk("reset_tick", 32'(tick_1hz), 32'd0);

    // start held through reset must not launch a game
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("held_start_idle", 32'(select), 32'd0);
    end
    start = 1'b0;
    cyc(1);
    chk("start_low_idle", 32'(select), 32'd0);
    start = 1'b1;
    cyc(1);
    chk("play_entry_select", 32'(select), 32'd1);
    chk("play_entry_score", score, 32'd0);
    chk("play_entry_secs", 32'(seconds_left), 32'd3);
    chk("play_entry_tick", 32'(tick_1hz), 32'd0);

    // full game: hits at edges 1,3,5,7,9 after entry
    hits_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      hit = (k <= 9) && (k % 2 == 1);
      if (hit) hits_seen++;
      cyc(1);
      chk("game_tick", 32'(tick_1hz), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("game_secs", 32'(seconds_left), 32'(3 - k / 4));
      chk("game_select", 32'(select), (k < 12) ? 32'd1 : 32'd2);
      chk("game_score", score, 32'(hits_seen));
    end
    hit = 1'b0;
    cyc(2);
    chk("over_select", 32'(select), 32'd2);
    chk("over_score", score, 32'd5);
    chk("over_secs", 32'(seconds_left), 32'd0);
    chk("over_tick", 32'(tick_1hz), 32'd0);

    // OVER -> IDLE keeps score, IDLE -> PLAY clears it
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    chk("over_to_idle_select", 32'(select), 32'd0);
    chk("over_to_idle_score", score, 32'd5);
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    chk("idle_to_play_select", 32'(select), 32'd1);
    chk("idle_to_play_score", score, 32'd0);

    // hit on final PLAY cycle counts, hit on first OVER cycle does not
    cyc(11);
    chk("pre_final_select", 32'(select), 32'd1);
    hit = 1'b1;
    cyc(1);
    chk("final_hit_score", score, 32'd1);
    chk("final_hit_select", 32'(select), 32'd2);
    cyc(1);
    chk("over_hit_score", score, 32'd1);
    hit = 1'b0;

    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    chk("game3_idle_score", score, 32'd1);
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    chk("game3_play_select", 32'(select), 32'd1);

    // saturation
    dut.score_q = 32'hFFFF_FFFE;
    hit = 1'b1;
    cyc(1);
    chk("sat_hit1", score, 32'hFFFF_FFFF);
    cyc(1);
    chk("sat_hit2", score, 32'hFFFF_FFFF);
    cyc(1);
    chk("sat_hit3", score, 32'hFFFF_FFFF);

    // reset on what would be a terminal-count edge, with hit asserted
    reset = 1'b1;
    cyc(1);
    chk("midplay_reset_select", 32'(select), 32'd0);
    chk("midplay_reset_score", score, 32'd0);
    chk("midplay_reset_secs", 32'(seconds_left), 32'd3);
    chk("midplay_reset_tick", 32'(tick_1hz), 32'd0);
    reset = 1'b0;
    hit   = 1'b0;
    cyc(2);
    chk("post_reset_idle", 32'(select), 32'd0);
    chk("post_reset_tick", 32'(tick_1hz), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
